background_loader: RTL

- Consumer end of the game FSM's background interface: on a load_background pulse it copies the selected background map from map ROM into the tile framebuffer.
- Sits between the game state machine, the map ROM bank and the framebuffer write port.
- One ROM read per framebuffer cell, in raster order.
- Reports busy while copying and pulses done once a full map has been written.

---
 rtl/background_loader_if.sv | 29 ++
 rtl/background_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/background_loader_if.sv
// Background loader bus: game FSM request, map ROM read port and
// framebuffer write port grouped into one bundle.
interface background_loader_if #(
    parameter int ADDR_W = 13
);
    logic              load_background;
    logic [2:0]        background_select;
    logic [2:0]        rom_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [3:0]        fb_data;
    logic              fb_ready;
    logic              busy;
    logic              done;

    // Loader side
    modport slave (
        input  load_background, background_select, rom_data, fb_ready,
        output rom_sel, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );

    // Environment side (game FSM, ROM bank, framebuffer)
    modport master (
        output load_background, background_select, rom_data, fb_ready,
        input  rom_sel, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/background_loader.sv
// Background loader: on a load request copies the selected map from the
// map ROM into the tile framebuffer, one ROM read per cell, raster order.
module background_loader #(
    parameter int MAP_W       = 80,
    parameter int MAP_H       = 60,
    parameter int ADDR_W      = 13,
    parameter int NUM_MAPS    = 5,
    parameter int ROM_LATENCY = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    background_loader_if.slave  bg_if
);
    localparam int                CELLS    = MAP_W * MAP_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS - 1);
    localparam int                CNT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] w_index_next;
    logic [2:0]        r_rom_sel;
    logic [2:0]        w_rom_sel_next;
    logic [CNT_W-1:0]  r_wait;
    logic [CNT_W-1:0]  w_wait_next;
    logic              w_busy;
    logic              w_write;
    logic              w_done;

    // State, cell index, latched map select and ROM wait counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_rom_sel <= '0;
            r_wait    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_index   <= w_index_next;
            r_rom_sel <= w_rom_sel_next;
            r_wait    <= w_wait_next;
        end
    end

    // Next-state logic and per-state outputs
    always_comb begin
        w_state_next   = r_state;
        w_index_next   = r_index;
        w_rom_sel_next = r_rom_sel;
        w_wait_next    = r_wait;
        w_busy         = 1'b0;
        w_write        = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_IDLE;
            end
            S_ARM: begin
                w_busy = 1'b1;
                // The game FSM updates the select on the load edge, so it is
                // only trustworthy one cycle later, here.
                if (int'(bg_if.background_select) < NUM_MAPS) begin
                    w_rom_sel_next = bg_if.background_select;
                end else begin
                    w_rom_sel_next = '0;
                end
                w_index_next = '0;
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_busy      = 1'b1;
                w_wait_next = CNT_W'(ROM_LATENCY - 1);
                if (ROM_LATENCY > 1) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_WRITE;
                end
            end
            S_WAIT: begin
                w_busy      = 1'b1;
                w_wait_next = r_wait - CNT_W'(1);
                if (r_wait <= CNT_W'(1)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_busy  = 1'b1;
                w_write = 1'b1;
                if (bg_if.fb_ready) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_index_next = r_index + ADDR_W'(1);
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A load request from any state (re)starts the copy; an aborted
        // copy never reaches DONE, so it produces no done pulse.
        if (bg_if.load_background) begin
            w_state_next = S_ARM;
        end
    end

    // rom_addr and fb_addr both follow the index, which only changes on
    // write completion or in ARM, so the ROM sees a stable address.
    assign bg_if.rom_sel  = r_rom_sel;
    assign bg_if.rom_addr = r_index;
    assign bg_if.fb_addr  = r_index;
    assign bg_if.fb_we    = w_write;
    assign bg_if.fb_data  = w_write ? bg_if.rom_data : '0;
    assign bg_if.busy     = w_busy;
    assign bg_if.done     = w_done;
endmodule
